// File: rtl/longop_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : longop_scheduler_pkg
// Description : Shared unit-select codes, slot state encoding and default widths
//               for the long-op scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package longop_scheduler_pkg;

    localparam logic UNIT_MCYCLE = 1'b0;
    localparam logic UNIT_FPU    = 1'b1;

    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } slot_state_t;

    function automatic logic other_unit(input logic unit);
        return ~unit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/longop_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : longop_scheduler_if
// Description : Pipeline/unit-facing signal bundle of the long-op scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface longop_scheduler_if
    import longop_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_W = c_DEFAULT_REG_ADDR_W
);
    logic                          IssueValid;
    logic                          IssueUnit;
    logic [REG_ADDR_W-1:0]         IssueWA3;
    logic                          IssueReady;
    logic [REG_ADDR_W-1:0]         RA1D;
    logic [REG_ADDR_W-1:0]         RA2D;
    logic [REG_ADDR_W-1:0]         WA3D;
    logic                          RegWriteD;
    logic                          LongOpHazard;
    logic                          MStart;
    logic                          FPUStart;
    logic                          MCycleBusy;
    logic                          FPUBusy;
    logic                          MCycleDone;
    logic                          FPUDone;
    logic [DATA_WIDTH-1:0]         MCycleResult;
    logic [DATA_WIDTH-1:0]         FPUResult;
    logic                          RegWriteW;
    logic                          LWE;
    logic [REG_ADDR_W-1:0]         LWA3;
    logic [DATA_WIDTH-1:0]         LWD;
    logic                          WbStall;
    logic [(1<<REG_ADDR_W)-1:0]    Pending;

    modport master (
        output IssueValid, IssueUnit, IssueWA3, RA1D, RA2D, WA3D, RegWriteD,
               MCycleBusy, FPUBusy, MCycleDone, FPUDone, MCycleResult, FPUResult,
               RegWriteW,
        input  IssueReady, LongOpHazard, MStart, FPUStart, LWE, LWA3, LWD,
               WbStall, Pending
    );

    modport slave (
        input  IssueValid, IssueUnit, IssueWA3, RA1D, RA2D, WA3D, RegWriteD,
               MCycleBusy, FPUBusy, MCycleDone, FPUDone, MCycleResult, FPUResult,
               RegWriteW,
        output IssueReady, LongOpHazard, MStart, FPUStart, LWE, LWA3, LWD,
               WbStall, Pending
    );

endinterface
`default_nettype wire

// File: rtl/longop_scheduler_slot.sv
`default_nettype none
// ============================================================================
// Module      : longop_slot
// Description : Per-unit tracker: IDLE/RUN/HOLD FSM, destination register,
//               result buffer and registered start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module longop_slot
    import longop_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_W = c_DEFAULT_REG_ADDR_W
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    i_accept,
    input  wire [REG_ADDR_W-1:0]   i_wa3,
    input  wire                    i_done,
    input  wire [DATA_WIDTH-1:0]   i_result,
    input  wire                    i_grant,
    output slot_state_t            o_state,
    output logic [REG_ADDR_W-1:0]  o_dest,
    output logic [DATA_WIDTH-1:0]  o_buf,
    output logic                   o_start,
    output logic                   o_hold
);

    slot_state_t             r_state;
    logic [REG_ADDR_W-1:0]   r_dest;
    logic [DATA_WIDTH-1:0]   r_buf;
    logic                    r_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
            r_buf   <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_accept) begin
                        r_dest  <= i_wa3;
                        r_start <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Done outside RUN is a stray pulse and is deliberately dropped.
                    if (i_done) begin
                        r_buf   <= i_result;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (i_grant) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_dest  = r_dest;
    assign o_buf   = r_buf;
    assign o_start = r_start;
    assign o_hold  = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: rtl/longop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : longop_scheduler
// Description : Issues long ops to the MCycle/FPU units, scoreboards their
//               destinations and arbitrates the shared long-op write port.
// Revision    : 1.0 - initial release
// ============================================================================
module longop_scheduler
    import longop_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_W = c_DEFAULT_REG_ADDR_W,
    parameter int MAX_WAIT   = 4
) (
    input  wire                CLK,
    input  wire                RESETn,
    longop_scheduler_if.slave  bus
);

    localparam int         c_NREGS    = 1 << REG_ADDR_W;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    slot_state_t             w_state  [2];
    logic [REG_ADDR_W-1:0]   w_dest   [2];
    logic [DATA_WIDTH-1:0]   w_buf    [2];
    logic [DATA_WIDTH-1:0]   w_result [2];
    logic [1:0]              w_accept;
    logic [1:0]              w_done;
    logic [1:0]              w_hold;
    logic [1:0]              w_start;
    logic [1:0]              w_grant;

    logic                    w_ready;
    logic                    w_issue_hit;
    logic                    w_lwe;
    logic [REG_ADDR_W-1:0]   w_lwa3;
    logic [DATA_WIDTH-1:0]   w_lwd;
    logic [c_NREGS-1:0]      w_pending_next;
    logic [3:0]              w_wait_next;
    logic                    w_unused;

    logic [c_NREGS-1:0]      r_pending;
    logic                    r_rr;
    logic [3:0]              r_wait;
    logic                    r_wbstall;

    assign w_done      = {bus.FPUDone, bus.MCycleDone};
    assign w_result[0] = bus.MCycleResult;
    assign w_result[1] = bus.FPUResult;
    assign w_unused    = bus.MCycleBusy ^ bus.FPUBusy;

    // Gated by RESETn so IssueReady reads low while reset is held.
    assign w_ready  = RESETn & bus.IssueValid
                    & (w_state[bus.IssueUnit] == ST_IDLE)
                    & ~r_pending[bus.IssueWA3];
    assign w_accept = {w_ready & (bus.IssueUnit == UNIT_FPU),
                       w_ready & (bus.IssueUnit == UNIT_MCYCLE)};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            longop_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .REG_ADDR_W (REG_ADDR_W)
            ) u_slot (
                .clk      (CLK),
                .rst_n    (RESETn),
                .i_accept (w_accept[gi]),
                .i_wa3    (bus.IssueWA3),
                .i_done   (w_done[gi]),
                .i_result (w_result[gi]),
                .i_grant  (w_grant[gi]),
                .o_state  (w_state[gi]),
                .o_dest   (w_dest[gi]),
                .o_buf    (w_buf[gi]),
                .o_start  (w_start[gi]),
                .o_hold   (w_hold[gi])
            );
        end
    endgenerate

    always_comb begin
        w_grant = 2'b00;
        if (!bus.RegWriteW) begin
            if (w_hold == 2'b11) begin
                w_grant[r_rr] = 1'b1;
            end else begin
                w_grant = w_hold;
            end
        end
    end

    assign w_lwe  = |w_grant;
    assign w_lwa3 = w_grant[1] ? w_dest[1] : (w_grant[0] ? w_dest[0] : '0);
    assign w_lwd  = w_grant[1] ? w_buf[1]  : (w_grant[0] ? w_buf[0]  : '0);

    // Clear and set never collide: an accepted issue needs its bit already clear.
    always_comb begin
        w_pending_next = r_pending;
        if (w_lwe) begin
            w_pending_next[w_lwa3] = 1'b0;
        end
        if (w_ready) begin
            w_pending_next[bus.IssueWA3] = 1'b1;
        end
    end

    always_comb begin
        w_wait_next = r_wait;
        if (w_lwe) begin
            w_wait_next = '0;
        end else if ((|w_hold) && (r_wait != 4'hF)) begin
            w_wait_next = r_wait + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pending <= '0;
            r_rr      <= UNIT_MCYCLE;
            r_wait    <= '0;
            r_wbstall <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_wait    <= w_wait_next;
            r_wbstall <= (w_wait_next >= c_MAX_WAIT);
            if (w_lwe) begin
                r_rr <= other_unit(w_grant[1]);
            end
        end
    end

    assign w_issue_hit = w_ready & ((bus.IssueWA3 == bus.RA1D)
                                  | (bus.IssueWA3 == bus.RA2D)
                                  | (bus.RegWriteD & (bus.IssueWA3 == bus.WA3D)));

    assign bus.LongOpHazard = r_pending[bus.RA1D] | r_pending[bus.RA2D]
                            | (bus.RegWriteD & r_pending[bus.WA3D])
                            | w_issue_hit;
    assign bus.IssueReady   = w_ready;
    assign bus.MStart       = w_start[0];
    assign bus.FPUStart     = w_start[1];
    assign bus.LWE          = w_lwe;
    assign bus.LWA3         = w_lwa3;
    assign bus.LWD          = w_lwd;
    assign bus.WbStall      = r_wbstall;
    assign bus.Pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_longop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_longop_scheduler
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level model of the long-op scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_longop_scheduler;
    import longop_scheduler_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MW = 4;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    longop_scheduler_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

    longop_scheduler #(
        .DATA_WIDTH (DW),
        .REG_ADDR_W (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    // reference model state
    logic [15:0] m_pend;
    int          m_ph [2];      // 0 free, 1 executing, 2 result waiting
    logic [3:0]  m_dst [2];
    logic [31:0] m_dat [2];
    bit          m_start [2];
    int          m_next_rr;
    int          m_wait;
    bit          m_stall;

    function automatic logic [57:0] out_vec();
        return {bus.IssueReady, bus.LongOpHazard, bus.MStart, bus.FPUStart, bus.LWE,
                bus.WbStall, bus.LWA3, bus.LWD, bus.Pending};
    endfunction

    task automatic nc();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus.IssueValid = 1'b0; bus.IssueUnit = 1'b0; bus.IssueWA3 = '0;
        bus.RA1D = '0; bus.RA2D = '0; bus.WA3D = '0; bus.RegWriteD = 1'b0;
        bus.MCycleBusy = 1'b0; bus.FPUBusy = 1'b0;
        bus.MCycleDone = 1'b0; bus.FPUDone = 1'b0;
        bus.MCycleResult = '0; bus.FPUResult = '0; bus.RegWriteW = 1'b0;
    endtask

    task automatic drive_issue(input logic unit, input logic [3:0] wa3);
        bus.IssueValid = 1'b1; bus.IssueUnit = unit; bus.IssueWA3 = wa3;
    endtask

    task automatic issue_one(input logic unit, input logic [3:0] wa3);
        drive_issue(unit, wa3);
        nc();
        bus.IssueValid = 1'b0;
    endtask

    task automatic pulse_reset();
        RESETn = 1'b0;
        clear_inputs();
        nc(); nc();
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESETn = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 58'd0) begin
            errors++; $display("FAIL reset_held: outputs=%h expected 0", out_vec());
        end
        nc(); nc();
        RESETn = 1'b1;
        #1;
        checks++;
        if (out_vec() !== 58'd0) begin
            errors++; $display("FAIL reset_release: outputs=%h expected 0", out_vec());
        end
    endtask

    task automatic test_issue_writeback();
        logic [31:0] res = $urandom;
        drive_issue(UNIT_MCYCLE, 4'd3);
        #1;
        checks++;
        if (bus.IssueReady !== 1'b1) begin
            errors++; $display("FAIL basic_accept: IssueReady=%b expected 1", bus.IssueReady);
        end
        nc();
        bus.IssueValid = 1'b0;
        #1;
        checks++;
        if ({bus.MStart, bus.Pending} !== {1'b1, 16'h0008}) begin
            errors++; $display("FAIL basic_start: MStart=%b Pending=%h expected 1/0008", bus.MStart, bus.Pending);
        end
        bus.RA1D = 4'd3;
        #1;
        checks++;
        if (bus.LongOpHazard !== 1'b1) begin
            errors++; $display("FAIL hazard_ra1: LongOpHazard=%b expected 1", bus.LongOpHazard);
        end
        bus.RA1D = 4'd0;
        drive_issue(UNIT_FPU, 4'd3);
        #1;
        checks++;
        if (bus.IssueReady !== 1'b0) begin
            errors++; $display("FAIL pending_refuse: IssueReady=%b expected 0", bus.IssueReady);
        end
        bus.IssueValid = 1'b0;
        nc();
        #1;
        checks++;
        if (bus.MStart !== 1'b0) begin
            errors++; $display("FAIL start_one_cycle: MStart=%b expected 0", bus.MStart);
        end
        nc(); nc(); nc();
        bus.MCycleDone = 1'b1; bus.MCycleResult = res;
        #1;
        checks++;
        if (bus.LWE !== 1'b0) begin
            errors++; $display("FAIL done_cycle_lwe: LWE=%b expected 0", bus.LWE);
        end
        nc();
        bus.MCycleDone = 1'b0;
        drive_issue(UNIT_MCYCLE, 4'd5);
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD, bus.IssueReady} !== {1'b1, 4'd3, res, 1'b0}) begin
            errors++; $display("FAIL basic_writeback: LWE=%b LWA3=%0d LWD=%h IssueReady=%b expected 1/3/%h/0",
                               bus.LWE, bus.LWA3, bus.LWD, bus.IssueReady, res);
        end
        bus.IssueValid = 1'b0;
        nc();
        #1;
        checks++;
        if ({bus.LWE, bus.Pending} !== 17'd0) begin
            errors++; $display("FAIL basic_clear: LWE=%b Pending=%h expected 0/0000", bus.LWE, bus.Pending);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] a = $urandom, b = $urandom, c = $urandom, d = $urandom, e = $urandom;
        pulse_reset();
        issue_one(UNIT_MCYCLE, 4'd1);
        issue_one(UNIT_FPU, 4'd2);
        bus.MCycleDone = 1'b1; bus.MCycleResult = a;
        bus.FPUDone = 1'b1; bus.FPUResult = b;
        nc();
        bus.MCycleDone = 1'b0; bus.FPUDone = 1'b0;
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD} !== {1'b1, 4'd1, a}) begin
            errors++; $display("FAIL rr_first_m: LWE=%b LWA3=%0d LWD=%h expected 1/1/%h", bus.LWE, bus.LWA3, bus.LWD, a);
        end
        nc();
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD} !== {1'b1, 4'd2, b}) begin
            errors++; $display("FAIL rr_then_f: LWE=%b LWA3=%0d LWD=%h expected 1/2/%h", bus.LWE, bus.LWA3, bus.LWD, b);
        end
        nc();
        issue_one(UNIT_MCYCLE, 4'd4);
        bus.MCycleDone = 1'b1; bus.MCycleResult = c;
        nc();
        bus.MCycleDone = 1'b0;
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD} !== {1'b1, 4'd4, c}) begin
            errors++; $display("FAIL rr_single: LWE=%b LWA3=%0d LWD=%h expected 1/4/%h", bus.LWE, bus.LWA3, bus.LWD, c);
        end
        nc();
        issue_one(UNIT_MCYCLE, 4'd5);
        issue_one(UNIT_FPU, 4'd6);
        bus.MCycleDone = 1'b1; bus.MCycleResult = d;
        bus.FPUDone = 1'b1; bus.FPUResult = e;
        nc();
        bus.MCycleDone = 1'b0; bus.FPUDone = 1'b0;
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD} !== {1'b1, 4'd6, e}) begin
            errors++; $display("FAIL rr_first_f: LWE=%b LWA3=%0d LWD=%h expected 1/6/%h", bus.LWE, bus.LWA3, bus.LWD, e);
        end
        nc();
        #1;
        checks++;
        if ({bus.LWE, bus.LWA3, bus.LWD} !== {1'b1, 4'd5, d}) begin
            errors++; $display("FAIL rr_then_m: LWE=%b LWA3=%0d LWD=%h expected 1/5/%h", bus.LWE, bus.LWA3, bus.LWD, d);
        end
        nc();
    endtask

    task automatic test_wbstall();
        issue_one(UNIT_MCYCLE, 4'd7);
        bus.RegWriteW = 1'b1;
        bus.MCycleDone = 1'b1; bus.MCycleResult = $urandom;
        nc();
        bus.MCycleDone = 1'b0;
        for (int i = 0; i < MW; i++) begin
            #1;
            checks++;
            if ({bus.WbStall, bus.LWE} !== 2'b00) begin
                errors++; $display("FAIL stall_early[%0d]: WbStall=%b LWE=%b expected 0/0", i, bus.WbStall, bus.LWE);
            end
            nc();
        end
        #1;
        checks++;
        if ({bus.WbStall, bus.LWE} !== 2'b10) begin
            errors++; $display("FAIL stall_rise: WbStall=%b LWE=%b expected 1/0", bus.WbStall, bus.LWE);
        end
        nc();
        bus.RegWriteW = 1'b0;
        #1;
        checks++;
        if ({bus.WbStall, bus.LWE, bus.LWA3} !== {1'b1, 1'b1, 4'd7}) begin
            errors++; $display("FAIL stall_grant: WbStall=%b LWE=%b LWA3=%0d expected 1/1/7", bus.WbStall, bus.LWE, bus.LWA3);
        end
        nc();
        #1;
        checks++;
        if ({bus.WbStall, bus.LWE, bus.Pending} !== 18'd0) begin
            errors++; $display("FAIL stall_fall: WbStall=%b LWE=%b Pending=%h expected 0/0/0000", bus.WbStall, bus.LWE, bus.Pending);
        end
    endtask

    task automatic test_refuse();
        issue_one(UNIT_FPU, 4'd8);
        drive_issue(UNIT_FPU, 4'd9);
        #1;
        checks++;
        if (bus.IssueReady !== 1'b0) begin
            errors++; $display("FAIL busy_refuse: IssueReady=%b expected 0", bus.IssueReady);
        end
        nc();
        bus.IssueValid = 1'b0;
        #1;
        checks++;
        if ({bus.FPUStart, bus.Pending} !== {1'b0, 16'h0100}) begin
            errors++; $display("FAIL busy_no_start: FPUStart=%b Pending=%h expected 0/0100", bus.FPUStart, bus.Pending);
        end
        bus.FPUDone = 1'b1; bus.FPUResult = $urandom;
        nc();
        bus.FPUDone = 1'b0;
        drive_issue(UNIT_FPU, 4'd8);
        #1;
        checks++;
        if ({bus.LWE, bus.IssueReady} !== 2'b10) begin
            errors++; $display("FAIL grant_cycle_refuse: LWE=%b IssueReady=%b expected 1/0", bus.LWE, bus.IssueReady);
        end
        nc();
        bus.IssueValid = 1'b0;
        #1;
        checks++;
        if ({bus.FPUStart, bus.Pending} !== 17'd0) begin
            errors++; $display("FAIL grant_cycle_clear: FPUStart=%b Pending=%h expected 0/0000", bus.FPUStart, bus.Pending);
        end
        bus.FPUDone = 1'b1; bus.MCycleDone = 1'b1;
        nc();
        bus.FPUDone = 1'b0; bus.MCycleDone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.LWE !== 1'b0) begin
                errors++; $display("FAIL idle_done[%0d]: LWE=%b expected 0", i, bus.LWE);
            end
            nc();
        end
    endtask

    task automatic test_reset_mid();
        issue_one(UNIT_MCYCLE, 4'd10);
        bus.RegWriteW = 1'b1;
        bus.MCycleDone = 1'b1; bus.MCycleResult = $urandom;
        nc();
        bus.MCycleDone = 1'b0;
        #1;
        RESETn = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 58'd0) begin
            errors++; $display("FAIL reset_mid: outputs=%h expected 0", out_vec());
        end
        nc();
        RESETn = 1'b1;
        bus.RegWriteW = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.LWE, bus.Pending} !== 17'd0) begin
                errors++; $display("FAIL reset_mid_after[%0d]: LWE=%b Pending=%h expected 0/0000", i, bus.LWE, bus.Pending);
            end
            nc();
        end
    endtask

    task automatic test_random();
        pulse_reset();
        m_pend = '0; m_next_rr = 0; m_wait = 0; m_stall = 0;
        for (int u = 0; u < 2; u++) begin
            m_ph[u] = 0; m_dst[u] = '0; m_dat[u] = '0; m_start[u] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            int           gnt;
            bit           e_ready, e_haz;
            logic [3:0]   e_lwa3;
            logic [31:0]  e_lwd;
            logic [57:0]  e_vec;
            int           iu;
            bus.IssueValid   = ($urandom_range(1) == 1);
            bus.IssueUnit    = ($urandom_range(1) == 1);
            bus.IssueWA3     = 4'($urandom_range(7));
            bus.RA1D         = 4'($urandom_range(7));
            bus.RA2D         = 4'($urandom_range(7));
            bus.WA3D         = 4'($urandom_range(7));
            bus.RegWriteD    = ($urandom_range(1) == 1);
            bus.MCycleBusy   = ($urandom_range(1) == 1);
            bus.FPUBusy      = ($urandom_range(1) == 1);
            bus.MCycleDone   = ($urandom_range(3) == 0);
            bus.FPUDone      = ($urandom_range(3) == 0);
            bus.MCycleResult = $urandom;
            bus.FPUResult    = $urandom;
            bus.RegWriteW    = m_stall ? 1'b0 : ($urandom_range(2) != 0);
            #1;
            iu = bus.IssueUnit ? 1 : 0;
            e_ready = bus.IssueValid && (m_ph[iu] == 0) && !m_pend[bus.IssueWA3];
            gnt = -1;
            if (!bus.RegWriteW) begin
                if (m_ph[0] == 2 && m_ph[1] == 2) gnt = m_next_rr;
                else if (m_ph[0] == 2)            gnt = 0;
                else if (m_ph[1] == 2)            gnt = 1;
            end
            e_lwa3 = (gnt >= 0) ? m_dst[gnt] : 4'd0;
            e_lwd  = (gnt >= 0) ? m_dat[gnt] : 32'd0;
            e_haz  = m_pend[bus.RA1D] || m_pend[bus.RA2D] || (bus.RegWriteD && m_pend[bus.WA3D])
                  || (e_ready && (bus.IssueWA3 == bus.RA1D || bus.IssueWA3 == bus.RA2D
                                  || (bus.RegWriteD && bus.IssueWA3 == bus.WA3D)));
            e_vec = {e_ready, e_haz, m_start[0], m_start[1], (gnt >= 0), m_stall, e_lwa3, e_lwd, m_pend};
            checks++;
            if (out_vec() !== e_vec) begin
                errors++; $display("FAIL random[%0d]: outputs=%h expected %h", cyc, out_vec(), e_vec);
            end
            if (gnt >= 0) begin
                m_pend[m_dst[gnt]] = 1'b0;
                m_ph[gnt] = 0;
                m_next_rr = 1 - gnt;
                m_wait = 0;
            end else if (m_ph[0] == 2 || m_ph[1] == 2) begin
                m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            end
            if (m_ph[0] == 1 && bus.MCycleDone) begin m_ph[0] = 2; m_dat[0] = bus.MCycleResult; end
            if (m_ph[1] == 1 && bus.FPUDone)    begin m_ph[1] = 2; m_dat[1] = bus.FPUResult; end
            m_start[0] = 0; m_start[1] = 0;
            if (e_ready) begin
                m_ph[iu] = 1; m_dst[iu] = bus.IssueWA3;
                m_pend[bus.IssueWA3] = 1'b1;
                m_start[iu] = 1;
            end
            m_stall = (m_wait >= MW);
            nc();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_issue_writeback();
        test_round_robin();
        test_wbstall();
        test_refuse();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
